conv3x3_stream: RTL and testbench

Streaming 3x3 convolution engine for the edge-detector datapath. It replaces the fixed 72-bit pre-windowed pixel block with a raster-order pixel stream, and builds the 3x3 window internally from two line buffers. The frame size is parametrised, and the kernel mode is selected per frame: Gaussian smoothing, Sobel X, Sobel Y, or Sobel magnitude. The block sits between the grayscale converter and the gradient/hysteresis stage, with valid/ready handshakes on both sides.

---
 rtl/conv3x3_stream.sv | 214 +++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 Gaussian / Sobel engine over a raster-order pixel stream.
// The window is two stored columns plus the incoming column (line buffer 1, line buffer 0, in_pixel).
module conv3x3_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int CNT_W = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int SUM_W = PIX_W + 4;
  localparam int COL_AW = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [SUM_W-1:0] PIX_MAX  = SUM_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             in_done_q, in_done_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             out_fire;
  logic             gen;
  logic [PIX_W-1:0] kern_res;

  function automatic logic [SUM_W-1:0] sum121(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  function automatic logic [SUM_W-1:0] absdiff(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [PIX_W-1:0] clamp(input logic [SUM_W-1:0] v);
    return (v > PIX_MAX) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  endfunction

  // Line buffers: read address is the next column so the registered read is ready when it is accepted.
  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb0_rd_q, lb1_rd_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_q[COL_AW-1:0]] <= in_pixel;
      lb1_mem[col_q[COL_AW-1:0]] <= lb0_rd_q;
    end
    lb0_rd_q <= lb0_mem[col_d[COL_AW-1:0]];
    lb1_rd_q <= lb1_mem[col_d[COL_AW-1:0]];
  end

  logic [PIX_W-1:0] new_col [3];
  logic [PIX_W-1:0] win_q   [3][2];
  logic [PIX_W-1:0] p       [3][3];

  assign new_col[0] = lb1_rd_q;
  assign new_col[1] = lb0_rd_q;
  assign new_col[2] = in_pixel;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= new_col[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      p[r][0] = win_q[r][0];
      p[r][1] = win_q[r][1];
      p[r][2] = new_col[r];
    end
  end

  logic [SUM_W-1:0] g_sum, g_shift, gx_abs, gy_abs;

  assign g_sum   = sum121(p[0][0], p[0][1], p[0][2])
                 + (sum121(p[1][0], p[1][1], p[1][2]) << 1)
                 + sum121(p[2][0], p[2][1], p[2][2]);
  assign g_shift = (g_sum + SUM_W'(8)) >> 4;
  assign gx_abs  = absdiff(sum121(p[0][2], p[1][2], p[2][2]), sum121(p[0][0], p[1][0], p[2][0]));
  assign gy_abs  = absdiff(sum121(p[2][0], p[2][1], p[2][2]), sum121(p[0][0], p[0][1], p[0][2]));

  always_comb begin
    kern_res = '0;
    unique case (mode_q)
      2'd0:    kern_res = clamp(g_shift);
      2'd1:    kern_res = clamp(gx_abs);
      2'd2:    kern_res = clamp(gy_abs);
      default: kern_res = clamp(gx_abs + gy_abs);
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign gen      = (row_q >= CNT_TWO) && (col_q >= CNT_TWO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (out_fire && out_last_q) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !in_done_q && (!out_valid_q || out_ready);
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mode_d      = mode_q;
    col_d       = col_q;
    row_d       = row_q;
    in_done_d   = in_done_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    if (state_q == S_IDLE && start) begin
      mode_d    = mode;
      col_d     = '0;
      row_d     = '0;
      in_done_d = 1'b0;
    end
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
        if (row_q == ROW_LAST) in_done_d = 1'b1;
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      // Outputs for c<2 would mix columns from the previous row, so they are never produced.
      if (gen) begin
        out_valid_d = 1'b1;
        out_pixel_d = kern_res;
        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      in_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      in_done_q   <= in_done_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: scoreboard bench for conv3x3_stream on a 16x12 frame.
// Expected outputs come from a direct 3x3 reference computed over the stimulus image.
module tb_conv3x3_stream;
  localparam int PW   = 8;
  localparam int W    = 16;
  localparam int H    = 12;
  localparam int NOUT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_pixel;
  logic          out_last;
  logic          busy;
  logic          done;

  conv3x3_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pixel(out_pixel),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int img [H][W];
  int exp_q [$];
  int cap [NOUT];

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic int golden(input int m, input int r, input int c);
    int gk [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int xk [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int yk [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int s = 0;
    int gx = 0;
    int gy = 0;
    int px;
    int ax;
    int ay;
    for (int i = 0; i < 9; i++) begin
      px = img[r - 1 + i / 3][c - 1 + i % 3];
      s  += gk[i] * px;
      gx += xk[i] * px;
      gy += yk[i] * px;
    end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m)
      0:       return (s + 8) / 16;
      1:       return (ax > 255) ? 255 : ax;
      2:       return (ay > 255) ? 255 : ay;
      default: return (ax + ay > 255) ? 255 : ax + ay;
    endcase
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 5 && c == 5) ? 255 : 0;
          2:       img[r][c] = (c >= 8) ? 255 : 0;
          3:       img[r][c] = (r >= 6) ? 50 : 0;
          default: img[r][c] = int'($urandom_range(255, 0));
        endcase
      end
    end
  endtask

  task automatic run_frame(input int m, input bit bp, input int abort_at, input int mid_start_at);
    int  idx = 0;
    int  nout = 0;
    int  cyc = 0;
    int  ndone = 0;
    int  e;
    int  r;
    int  c;
    int  held_pix = 0;
    int  held_last = 0;
    bit  fin = 1'b0;
    bit  aborted = 1'b0;
    bit  stall_prev = 1'b0;
    bit  mid_sent = 1'b0;
    exp_q.delete();
    @(negedge clk);
    mode  = 2'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = 2'(m + 1);
    #1;
    check("busy_run", int'(busy), 1);
    while (!fin && !aborted && cyc < 5000) begin
      in_valid  = (idx < W * H) && (!bp || ($urandom_range(1, 0) == 1));
      in_pixel  = in_valid ? 8'(img[idx / W][idx % W]) : 8'($urandom);
      out_ready = !bp || ($urandom_range(1, 0) == 1);
      start     = (mid_start_at >= 0) && (idx >= mid_start_at) && !mid_sent;
      if (start) mid_sent = 1'b1;
      #1;
      if (stall_prev) begin
        check("stall_pix", int'(out_pixel), held_pix);
        check("stall_last", int'(out_last), held_last);
      end
      stall_prev = out_valid && !out_ready;
      held_pix   = int'(out_pixel);
      held_last  = int'(out_last);
      if (done) ndone++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'(out_pixel), -1);
        end else begin
          e = exp_q.pop_front();
          check("out_pix", int'(out_pixel), e & 255);
          check("out_last", int'(out_last), e >> 8);
        end
        if (nout < NOUT) cap[nout] = int'(out_pixel);
        $display("mode %0d out %0d: pixel=%0d last=%0d", m, nout, out_pixel, out_last);
        nout++;
        fin = out_last;
      end
      if (in_valid && in_ready) begin
        r = idx / W;
        c = idx % W;
        if (r >= 2 && c >= 2)
          exp_q.push_back(golden(m, r - 1, c - 1) | ((r == H - 1 && c == W - 1) ? 256 : 0));
        idx++;
      end
      if (abort_at >= 0 && idx >= abort_at) aborted = 1'b1;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_pixel", int'(out_pixel), 0);
      check("rst_out_last", int'(out_last), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (4) begin
        @(negedge clk);
        #1;
        if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_busy", int'(busy), 0);
    end else begin
      check("frame_finished", int'(fin), 1);
      #1;
      check("done_pulse", int'(done), 1);
      check("busy_finish", int'(busy), 0);
      @(negedge clk);
      #1;
      check("done_clear", int'(done), 0);
      check("busy_idle", int'(busy), 0);
      check("in_ready_idle", int'(in_ready), 0);
      check("done_in_run", ndone, 0);
      check("out_count", nout, NOUT);
      check("sb_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_pixel", int'(out_pixel), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;

    fill(0);
    run_frame(0, 1'b0, -1, -1);
    check("const_first", cap[0], 100);
    check("const_last", cap[NOUT - 1], 100);

    fill(1);
    run_frame(0, 1'b0, -1, -1);
    check("impulse_centre", cap[60], 64);
    check("impulse_edge_h", cap[61], 32);
    check("impulse_edge_v", cap[74], 32);
    check("impulse_diag", cap[45], 16);
    check("impulse_far", cap[0], 0);

    fill(2);
    run_frame(1, 1'b0, -1, -1);
    check("vstep_gx_c7", cap[6], 255);
    check("vstep_gx_c8", cap[7], 255);
    check("vstep_gx_c6", cap[5], 0);
    run_frame(2, 1'b0, -1, -1);
    check("vstep_gy_c7", cap[6], 0);
    run_frame(3, 1'b0, -1, -1);
    check("vstep_mag_c8", cap[7], 255);

    fill(3);
    run_frame(2, 1'b0, -1, 50);
    check("hstep_r5", cap[4 * 14 + 3], 200);
    check("hstep_r6", cap[5 * 14 + 3], 200);
    check("hstep_r4", cap[3 * 14 + 3], 0);

    fill(4);
    run_frame(3, 1'b0, -1, -1);
    run_frame(3, 1'b1, -1, -1);
    run_frame(0, 1'b1, -1, -1);

    fill(4);
    run_frame(0, 1'b0, 100, -1);
    run_frame(0, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
